// File: rtl/fir_ntap_serial_mac_pkg.sv
// fir_ntap_serial_mac_pkg
// Shared definitions for the serial-MAC FIR filter: the controller state
// encoding and a constant-evaluable ceil(log2) used to size the tap index.
// No ports; imported by fir_ntap_serial_mac and fir_mac_unit.
package fir_ntap_serial_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_ntap_serial_mac_mac_unit.sv
// fir_mac_unit
// Signed multiply-accumulate register used by the serial FIR filter.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clr          : load zero into the accumulator (wins over en)
//   en           : add a*b into the accumulator
//   a, b         : signed sample and coefficient operands
//   acc          : registered accumulator value
module fir_mac_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_W       = 35
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [DATA_WIDTH-1:0]  a,
  input  logic signed [COEFF_WIDTH-1:0] b,
  output logic signed [ACC_W-1:0]       acc
);

  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  // Operands are widened to the full product width before multiplying so
  // the product is exact; it is then sign-extended into the accumulator.
  always_comb begin
    prod  = PROD_W'(a) * PROD_W'(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_ntap_serial_mac.sv
// fir_ntap_serial_mac
// N-tap direct-form FIR filter evaluated one tap per cycle on a single MAC.
// Coefficients are written into a shadow bank at any time and copied to the
// active bank when a sample is accepted, so a running computation never sees
// a half-updated coefficient set.
// Ports:
//   clk, reset_n  : clock and asynchronous active-low reset
//   i_data        : signed input sample, taken when i_data_valid & o_data_ready
//   i_data_valid  : sample present
//   o_data_ready  : high only while idle
//   i_coeff_we    : write i_coeff_data into shadow tap i_coeff_addr
//   i_coeff_addr  : tap index; indices >= NUM_TAPS are dropped
//   i_coeff_data  : signed coefficient
//   o_data_sum    : rounded (optionally saturated) filter output, registered
//   o_data_valid  : one-cycle pulse when o_data_sum is updated
module fir_ntap_serial_mac
  import fir_ntap_serial_mac_pkg::*;
#(
  parameter int DATA_WIDTH           = 16,
  parameter int COEFF_WIDTH          = 16,
  parameter int COEFF_FRACTION_WIDTH = 15,
  parameter int NUM_TAPS             = 8,
  parameter int SATURATE             = 0,
  localparam int AW    = clog2(NUM_TAPS),
  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + AW,
  localparam int OUT_W = DATA_WIDTH + COEFF_WIDTH - COEFF_FRACTION_WIDTH + AW
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
  input  logic                          i_data_valid,
  output logic                          o_data_ready,
  input  logic                          i_coeff_we,
  input  logic [AW-1:0]                 i_coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0] i_coeff_data,
  output logic signed [OUT_W-1:0]       o_data_sum,
  output logic                          o_data_valid
);

  localparam int F = COEFF_FRACTION_WIDTH;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]   TAP_COUNT = (AW + 1)'(NUM_TAPS);
  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(1) << (F - 1);
  localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [OUT_W-1:0] SAT_MIN = OUT_W'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  state_e state_q, state_d;

  logic [AW-1:0] idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]  x_q      [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  x_d      [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] shadow_q [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] shadow_d [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] active_q [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] active_d [NUM_TAPS];
  logic signed [OUT_W-1:0] sum_q, sum_d;
  logic valid_q, valid_d;

  logic ready;
  logic accept;
  logic mac_en;
  logic signed [DATA_WIDTH-1:0]  mac_a;
  logic signed [COEFF_WIDTH-1:0] mac_b;
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       rounded_full;
  logic signed [OUT_W-1:0]       rounded;
  logic                          unused_round_bits;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_data_valid) state_d = ST_MAC;
      ST_MAC:  if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; ready is a pure state decode so it is high during reset
  always_comb begin
    ready  = (state_q == ST_IDLE);
    accept = ready && i_data_valid;
    mac_en = (state_q == ST_MAC);
  end

  assign o_data_ready = ready;

  // Delay line, coefficient banks and tap index. The active bank copies the
  // shadow *register* contents, so a write landing on the accept edge only
  // reaches the shadow bank and is picked up by the following sample.
  always_comb begin
    idx_d    = idx_q;
    x_d      = x_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (accept) begin
      x_d[0] = i_data;
      for (int k = 1; k < NUM_TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
      active_d = shadow_q;
      idx_d    = '0;
    end else if (mac_en && (idx_q != LAST_IDX)) begin
      idx_d = idx_q + AW'(1);
    end
    if (i_coeff_we && ({1'b0, i_coeff_addr} < TAP_COUNT)) begin
      shadow_d[i_coeff_addr] = i_coeff_data;
    end
  end

  assign mac_a = x_q[idx_q];
  assign mac_b = active_q[idx_q];

  fir_mac_unit #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .ACC_W       (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (mac_en),
    .a       (mac_a),
    .b       (mac_b),
    .acc     (acc)
  );

  // Round half up, then drop the F fraction bits; ACC_W-F equals OUT_W so
  // taking the upper slice is an exact arithmetic shift.
  assign rounded_full      = acc + ROUND_K;
  assign rounded           = rounded_full[ACC_W-1:F];
  assign unused_round_bits = ^rounded_full[F-1:0];

  // Output register: loaded only in DONE, with a matching one-cycle pulse
  always_comb begin
    sum_d   = sum_q;
    valid_d = 1'b0;
    if (state_q == ST_DONE) begin
      valid_d = 1'b1;
      sum_d   = rounded;
      if (SATURATE != 0) begin
        if (rounded > SAT_MAX) begin
          sum_d = SAT_MAX;
        end else if (rounded < SAT_MIN) begin
          sum_d = SAT_MIN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      x_q      <= '{default: '0};
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      sum_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      x_q      <= x_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      sum_q    <= sum_d;
      valid_q  <= valid_d;
    end
  end

  assign o_data_sum   = sum_q;
  assign o_data_valid = valid_q;

endmodule

// File: tb/tb_fir_ntap_serial_mac.sv
// tb_fir_ntap_serial_mac
// Drives two filter instances (full-width and saturating) from shared inputs
// and compares every result with a sum-of-products reference model.
module tb_fir_ntap_serial_mac;

  localparam int NT = 8;
  localparam int OW = 20;

  logic clk = 1'b0;
  logic reset_n;
  logic signed [15:0] i_data;
  logic i_data_valid;
  logic i_coeff_we;
  logic [2:0] i_coeff_addr;
  logic signed [15:0] i_coeff_data;
  logic ready0, ready1, valid0, valid1;
  logic [OW-1:0] sum0, sum1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: sample history (newest first) and both banks
  int hist [NT];
  int shad [NT];
  int act  [NT];

  always #5 clk = ~clk;

  fir_ntap_serial_mac #(.NUM_TAPS(NT), .SATURATE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(ready0), .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr),
    .i_coeff_data(i_coeff_data), .o_data_sum(sum0), .o_data_valid(valid0)
  );

  fir_ntap_serial_mac #(.NUM_TAPS(NT), .SATURATE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(ready1), .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr),
    .i_coeff_data(i_coeff_data), .o_data_sum(sum1), .o_data_valid(valid1)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NT; k++) begin
      hist[k] = 0;
      shad[k] = 0;
      act[k]  = 0;
    end
  endfunction

  function automatic void model_accept(input int x);
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    for (int k = 0; k < NT; k++) act[k] = shad[k];
  endfunction

  function automatic logic [OW-1:0] model_result(input bit sat);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(hist[k]) * longint'(act[k]);
    r = (acc + 64'sd16384) >>> 15;
    if (sat) begin
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
    end
    return r[OW-1:0];
  endfunction

  task automatic write_coeff(input logic [2:0] a, input logic signed [15:0] d);
    i_coeff_we   = 1'b1;
    i_coeff_addr = a;
    i_coeff_data = d;
    @(negedge clk);
    i_coeff_we = 1'b0;
    shad[a] = int'(d);
  endtask

  // wmode: 0 no write, 1 write on the accept edge, 2 write during MAC
  task automatic apply_stimulus(input string tag, input logic signed [15:0] x, input int wmode,
                                input logic [2:0] waddr, input logic signed [15:0] wdata);
    int edges;
    logic [OW-1:0] e0, e1;
    edges = 0;
    while (ready0 !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check_output({tag, "_rdy"}, 32'(ready0), 32'd1);
    i_data       = x;
    i_data_valid = 1'b1;
    if (wmode == 1) begin
      i_coeff_we   = 1'b1;
      i_coeff_addr = waddr;
      i_coeff_data = wdata;
    end
    @(posedge clk);
    model_accept(int'(x));
    if (wmode == 1) shad[waddr] = int'(wdata);
    e0 = model_result(1'b0);
    e1 = model_result(1'b1);
    @(negedge clk);
    i_data_valid = 1'b0;
    i_coeff_we   = 1'b0;
    i_data       = 16'($urandom);
    check_output({tag, "_busy"}, 32'(ready0), 32'd0);
    edges = 1;
    if (wmode == 2) begin
      i_coeff_we   = 1'b1;
      i_coeff_addr = waddr;
      i_coeff_data = wdata;
      @(negedge clk);
      i_coeff_we = 1'b0;
      shad[waddr] = int'(wdata);
      edges++;
    end
    while (valid0 !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check_output({tag, "_lat"}, 32'(edges - 1), 32'(NT + 1));
    check_output({tag, "_v1"}, 32'(valid1), 32'd1);
    check_output({tag, "_sum0"}, 32'(sum0), 32'(e0));
    check_output({tag, "_sum1"}, 32'(sum1), 32'(e1));
    @(negedge clk);
    check_output({tag, "_pulse"}, 32'({valid0, valid1}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] imp_h [NT];
    int          imp_e [NT];
    logic [15:0] rnd_x [4];
    int          rnd_e [4];
    int          n_ready, n_pulse, last_ready, since;
    int          acc_cyc [$];
    logic [OW-1:0] exp0_q [$];
    logic [OW-1:0] exp1_q [$];
    int          c_acc;
    logic [OW-1:0] ex;

    imp_h = '{16'h1000, 16'h2000, 16'h2000, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0};
    imp_e = '{32'h800, 32'h1000, 32'h1000, 32'h800, 0, 0, 0, 0};
    rnd_x = '{16'h4000, 16'h3FFF, 16'hC000, 16'hBFFF};
    rnd_e = '{1, 0, 0, 32'h000FFFFF};

    reset_n = 1'b0;
    i_data = '0;
    i_data_valid = 1'b0;
    i_coeff_we = 1'b0;
    i_coeff_addr = '0;
    i_coeff_data = '0;
    model_reset();
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_sum0", 32'(sum0), 32'd0);
    check_output("rst_sum1", 32'(sum1), 32'd0);
    check_output("rst_valid", 32'({valid0, valid1}), 32'd0);
    check_output("rst_ready", 32'({ready0, ready1}), 32'd3);
    i_data = 16'h1234;
    i_data_valid = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("rst_ignored", 32'({ready0, ready1}), 32'd3);

    $display("[TB] impulse response");
    for (int k = 0; k < NT; k++) write_coeff(3'(k), imp_h[k]);
    for (int k = 0; k < NT; k++) begin
      apply_stimulus("imp", (k == 0) ? 16'sh4000 : 16'sh0, 0, 3'd0, 16'sh0);
      check_output("imp_spec", 32'(sum0), 32'(imp_e[k]));
    end

    $display("[TB] full-scale step");
    for (int k = 0; k < NT; k++) write_coeff(3'(k), 16'sh7FFF);
    for (int k = 0; k < NT; k++) apply_stimulus("step", 16'sh7FFF, 0, 3'd0, 16'sh0);
    check_output("step_full", 32'(sum0), 32'd262128);
    check_output("step_sat", 32'(sum1), 32'h7FFF);

    $display("[TB] rounding");
    write_coeff(3'd0, 16'sh0001);
    for (int k = 1; k < NT; k++) write_coeff(3'(k), 16'sh0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus("rnd", rnd_x[k], 0, 3'd0, 16'sh0);
      check_output("rnd_spec", 32'(sum0), 32'(rnd_e[k]));
    end

    $display("[TB] coefficient double buffering");
    write_coeff(3'd0, 16'sh1000);
    apply_stimulus("dbuf_mid", 16'sh4000, 2, 3'd0, 16'sh4000);
    check_output("dbuf_old", 32'(sum0), 32'h800);
    apply_stimulus("dbuf_new", 16'sh4000, 0, 3'd0, 16'sh0);
    check_output("dbuf_new", 32'(sum0), 32'h2000);
    apply_stimulus("dbuf_acc", 16'sh4000, 1, 3'd0, 16'sh1000);
    check_output("dbuf_acc", 32'(sum0), 32'h2000);
    apply_stimulus("dbuf_next", 16'sh4000, 0, 3'd0, 16'sh0);
    check_output("dbuf_next", 32'(sum0), 32'h800);

    $display("[TB] random samples and coefficients");
    for (int k = 0; k < NT; k++) write_coeff(3'(k), 16'($urandom));
    for (int n = 0; n < 16; n++) begin
      apply_stimulus("rand", 16'($urandom), int'($urandom_range(0, 2)),
                     3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("[TB] handshake with valid held high");
    n_ready = 0;
    n_pulse = 0;
    last_ready = -1;
    for (int c = 0; c < 112; c++) begin
      if (valid0 === 1'b1) begin
        n_pulse++;
        check_output("hs_queue", 32'(acc_cyc.size() > 0), 32'd1);
        if (acc_cyc.size() > 0) begin
          c_acc = acc_cyc.pop_front();
          check_output("hs_lat", 32'(c - c_acc - 1), 32'(NT + 1));
          ex = exp0_q.pop_front();
          check_output("hs_sum0", 32'(sum0), 32'(ex));
          ex = exp1_q.pop_front();
          check_output("hs_sum1", 32'(sum1), 32'(ex));
        end
      end
      if (c < 100) begin
        i_data_valid = 1'b1;
        i_data = 16'($urandom);
        if (ready0 === 1'b1) begin
          n_ready++;
          if (last_ready >= 0) begin
            since = c - last_ready;
            check_output("hs_spacing", 32'(since), 32'(NT + 2));
          end
          last_ready = c;
          model_accept(int'(i_data));
          acc_cyc.push_back(c);
          exp0_q.push_back(model_result(1'b0));
          exp1_q.push_back(model_result(1'b1));
        end
      end else begin
        i_data_valid = 1'b0;
      end
      @(negedge clk);
    end
    check_output("hs_accepts", 32'(n_ready), 32'd10);
    check_output("hs_pulses", 32'(n_pulse), 32'd10);

    $display("[TB] reset during MAC");
    i_data = 16'sh4000;
    i_data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("mid_busy", 32'(ready0), 32'd0);
    reset_n = 1'b0;
    #1;
    check_output("mid_sum0", 32'(sum0), 32'd0);
    check_output("mid_sum1", 32'(sum1), 32'd0);
    check_output("mid_valid", 32'({valid0, valid1}), 32'd0);
    check_output("mid_ready", 32'({ready0, ready1}), 32'd3);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_pulse = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (valid0 === 1'b1 || valid1 === 1'b1) n_pulse++;
    end
    check_output("mid_nopulse", 32'(n_pulse), 32'd0);
    apply_stimulus("mid_after", 16'($urandom), 0, 3'd0, 16'sh0);
    check_output("mid_zero", 32'(sum0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
